// File: rtl/raw_capture_ctrl.sv
// Capture sequencer between the sensor pixel port and the demosaic stage: arms on host
// commands, aligns to frame boundaries, and emits gated pixels with coordinates. Optional macro: RAW_SINGLE_SHOT_EN.
module raw_capture_ctrl #(
    parameter int DW       = 12,
    parameter int H_ACTIVE = 1280,
    parameter int V_ACTIVE = 960,
    parameter int CW       = 16
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic          iFVAL,
    input  logic          iLVAL,
    input  logic [DW-1:0] iDATA,
    input  logic          iSTART,
    input  logic          iEND,
`ifdef RAW_SINGLE_SHOT_EN
    input  logic          iSNAP,
`endif
    output logic [DW-1:0] oDATA,
    output logic          oDVAL,
    output logic [CW-1:0] oX_Cont,
    output logic [CW-1:0] oY_Cont,
    output logic [31:0]   oFrame_Cont,
    output logic          oBusy,
    output logic          oLine_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        ACTIVE = 2'd2,
        GAP    = 2'd3
    } stateT;

    localparam logic [CW-1:0] H_LIM = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_LIM = CW'(V_ACTIVE);

    stateT         state;
    stateT         nextState;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          stopPending;
    logic          fvalQ;
    logic          lvalQ;
    logic          fvalRise;
    logic          fvalFall;
    logic          lvalFall;
    logic          stopAtFall;
    logic          inActive;

`ifdef RAW_SINGLE_SHOT_EN
    logic singleShot;
    logic nextSingle;
`endif

    assign fvalRise = iFVAL & ~fvalQ;
    assign fvalFall = ~iFVAL & fvalQ;
    assign lvalFall = ~iLVAL & lvalQ;
    assign inActive = (state == ACTIVE);

    // A stop requested in the very cycle the frame ends still takes effect at that boundary.
`ifdef RAW_SINGLE_SHOT_EN
    assign stopAtFall = stopPending | iEND | singleShot;
`else
    assign stopAtFall = stopPending | iEND;
`endif

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        nextState = state;
`ifdef RAW_SINGLE_SHOT_EN
        nextSingle = singleShot;
`endif
        case (state)
            IDLE: begin
                if (iEND) begin
                    nextState = IDLE;
                end else if (iSTART) begin
                    nextState = ARMED;
`ifdef RAW_SINGLE_SHOT_EN
                    nextSingle = 1'b0;
                end else if (iSNAP) begin
                    nextState  = ARMED;
                    nextSingle = 1'b1;
`endif
                end
            end
            ARMED: begin
                if (iEND)          nextState = IDLE;
                else if (fvalRise) nextState = ACTIVE;
            end
            ACTIVE: begin
                if (fvalFall) nextState = stopAtFall ? IDLE : GAP;
            end
            GAP: begin
                if (iEND)          nextState = IDLE;
                else if (fvalRise) nextState = ACTIVE;
            end
            default: nextState = IDLE;
        endcase
    end

    // NOTE: all state here is sequential, so only non-blocking assignments are used.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state       <= IDLE;
            x           <= '0;
            y           <= '0;
            stopPending <= 1'b0;
            fvalQ       <= 1'b0;
            lvalQ       <= 1'b0;
            oDATA       <= '0;
            oDVAL       <= 1'b0;
            oX_Cont     <= '0;
            oY_Cont     <= '0;
            oFrame_Cont <= '0;
            oBusy       <= 1'b0;
            oLine_err   <= 1'b0;
`ifdef RAW_SINGLE_SHOT_EN
            singleShot  <= 1'b0;
`endif
        end else begin
            state <= nextState;
            fvalQ <= iFVAL;
            lvalQ <= iLVAL;
`ifdef RAW_SINGLE_SHOT_EN
            singleShot <= nextSingle;
`endif

            if (inActive && !fvalFall && iEND) stopPending <= 1'b1;
            else if (!inActive || fvalFall)    stopPending <= 1'b0;

            // Counters idle at zero outside ACTIVE so every frame starts at Bayer phase (0,0).
            if (!inActive || fvalFall) begin
                x <= '0;
                y <= '0;
            end else if (lvalFall) begin
                x <= '0;
                if (x != '0) y <= y + 1'b1;
            end else if (iFVAL && iLVAL) begin
                if (x != '1) x <= x + 1'b1;
            end

            oDATA     <= iDATA;
            oDVAL     <= inActive & iFVAL & iLVAL & (x < H_LIM) & (y < V_LIM);
            oX_Cont   <= x;
            oY_Cont   <= y;
            oLine_err <= inActive & lvalFall & (x != H_LIM);
            oBusy     <= (nextState != IDLE);

            if (inActive && fvalFall) oFrame_Cont <= oFrame_Cont + 32'd1;
        end
    end

endmodule

// File: doc/raw_capture_ctrl.md
Name: raw_capture_ctrl

Overview:
Capture sequencer between the sensor pixel interface and the Bayer-to-RGB demosaic stage.
- Arms and disarms capture on host commands and aligns every capture to a frame boundary.
- Generates the pixel/line coordinates that the demosaic uses to select Bayer phase.
- Gates data valid to the active window, counts captured frames, and flags malformed lines.

Parameters:
- DW, 12, pixel data width.
- H_ACTIVE, 1280, expected pixels per line; pixels beyond this are not forwarded.
- V_ACTIVE, 960, expected lines per frame; lines beyond this are not forwarded.
- CW, 16, width of the X/Y coordinate counters.

Ports:
- iCLK  in  1  pixel clock; the only clock.
- iRST  in  1  reset, synchronous, active-high.
- iFVAL  in  1  sensor frame valid.
- iLVAL  in  1  sensor line valid.
- iDATA  in  DW  sensor raw pixel.
- iSTART  in  1  single-cycle pulse; arm continuous capture.
- iEND  in  1  single-cycle pulse; stop capture.
- oDATA  out  DW  registered pixel to demosaic.
- oDVAL  out  1  pixel valid to demosaic.
- oX_Cont  out  CW  column index of oDATA.
- oY_Cont  out  CW  row index of oDATA.
- oFrame_Cont  out  32  completed captured frames.
- oBusy  out  1  high when state is not IDLE.
- oLine_err  out  1  one-cycle pulse on a line whose length is not H_ACTIVE.

Behaviour:
- Reset: iRST=1 at a clock edge clears all of the following; iRST mid-frame aborts the capture with no partial count.
  - state to IDLE.
  - oDATA, oDVAL, oX_Cont, oY_Cont, oFrame_Cont, oBusy, oLine_err to 0.
  - internal x/y counters, stop_pending, and prev-FVAL/LVAL registers to 0.
- Edge detection: fval_rise = iFVAL & !fval_q; fval_fall = !iFVAL & fval_q; lval_fall = !iLVAL & lval_q. fval_q and lval_q are registered copies of the inputs.
- States:
  - IDLE: iSTART moves to ARMED.
  - ARMED: fval_rise moves to ACTIVE. If iFVAL is already high when armed, the partial frame is skipped and the FSM waits for the next rise. iEND returns to IDLE.
  - ACTIVE: pixels are forwarded. iEND sets stop_pending. On fval_fall, go to IDLE if stop_pending (and clear it); otherwise go to GAP.
  - GAP: fval_rise moves to ACTIVE. iEND moves to IDLE.
- Command priority: iSTART and iEND in the same cycle means iEND wins. iSTART in ARMED, ACTIVE or GAP is ignored.
- Counting (ACTIVE only):
  - Each cycle with iFVAL & iLVAL, x increments; it saturates at 2^CW-1.
  - On lval_fall, x clears to 0 and y increments only if x != 0.
  - On fval_fall, x and y clear to 0.
  - Coordinates always start at (0,0) at frame start, so Bayer parity is fixed.
- Output pipeline (latency exactly 1 cycle from input sample):
  - oDATA <= iDATA every cycle.
  - oDVAL <= (state==ACTIVE) & iFVAL & iLVAL & (x < H_ACTIVE) & (y < V_ACTIVE).
  - oX_Cont <= x and oY_Cont <= y, where x and y are the pre-increment values for that pixel.
- oFrame_Cont increments by 1 on every fval_fall in ACTIVE and wraps mod 2^32.
- oLine_err pulses 1 cycle after lval_fall in ACTIVE when x != H_ACTIVE, covering both short and long lines. It is never asserted outside ACTIVE.
- oBusy is registered and equals (next state != IDLE).

Optional Feature:
RAW_SINGLE_SHOT_EN
- With the macro defined: adds input iSNAP (1 bit).
  - iSNAP in IDLE arms a single-frame capture: ARMED, then ACTIVE, then IDLE on fval_fall, never entering GAP.
  - iSTART has priority over iSNAP in the same cycle; iEND has priority over both.
- Without the macro: no iSNAP port; only continuous capture exists.

Test Plan (H_ACTIVE=8, V_ACTIVE=4):
1. Pulse iSTART while IDLE, then a frame of 4 lines x 8 pixels, data = 0..31 -> oDVAL high for 32 cycles, each 1 cycle after its input; oX_Cont 0..7 and oY_Cont 0..3 matching; oFrame_Cont=1; oLine_err never pulses; FSM ends in GAP.
2. iSTART while iFVAL=1 mid-frame -> oDVAL stays 0 for that frame; the next full frame is captured starting at (0,0).
3. iEND during line 2 of an active frame -> the rest of the frame is still forwarded; at fval_fall the FSM goes to IDLE; oBusy falls; the next frame is ignored with oFrame_Cont unchanged.
4. A line of 10 pixels, then a line of 6 pixels -> pixels x=8,9 have oDVAL=0; oLine_err pulses once after each of the two lines; oY_Cont advances normally.
5. iRST asserted mid-line -> next cycle all outputs are 0 and the FSM is IDLE; subsequent frames are ignored until iSTART.
6. With RAW_SINGLE_SHOT_EN: iSNAP, then 3 frames -> only the first frame is forwarded; oFrame_Cont=1; FSM is IDLE after the first fval_fall.
